// File: rtl/servo_cfg_tick.sv
// servo_cfg_tick: configuration and timebase stage for the VSLC servo PWM generator.
//
// Byte writes land in staging registers. An address-7 write requests a commit.
// The staged set is copied into the active registers in one edge, either at
// the generator's frame boundary (frame_sync) or immediately when the active
// configuration is disabled. The active registers drive the generator directly.
// A prescaler derives the servo_clk tick train from clk.
//
// Optional feature macro: SERVO_CFG_READBACK_EN (adds rd_addr/rd_data staging readback).
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   wr_valid/wr_ready write handshake; wr_addr selects the register, wr_data is the byte
//   frame_sync        one-clk pulse at the generator counter wrap
//   commit_pending    commit requested but not yet applied
//   servo_set_val     active set threshold
//   servo_reset_val   active reset threshold
//   servo_freq_val    active period {freq_hi, freq_lo}
//   servo_enabled     active enable
//   servo_value       active value bit
//   servo_clk         tick train: 1 clk high, prescale+1 clk low
//   rd_addr/rd_data   (readback build only) registered staging readback, 1 clk latency

module servo_cfg_tick #(
  parameter int unsigned           PRESCALE_W   = 8,
  parameter logic [PRESCALE_W-1:0] PRESCALE_RST = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [2:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        frame_sync,
  output logic        commit_pending,
  output logic [7:0]  servo_set_val,
  output logic [7:0]  servo_reset_val,
  output logic [15:0] servo_freq_val,
  output logic        servo_enabled,
  output logic        servo_value,
  output logic        servo_clk
`ifdef SERVO_CFG_READBACK_EN
  ,
  input  logic [2:0]  rd_addr,
  output logic [7:0]  rd_data
`endif
);

  // Counter is one bit wider so prescale+1 never overflows at all-ones.
  localparam int unsigned CNT_W = PRESCALE_W + 1;

  localparam logic [2:0] ADDR_SET    = 3'd0;
  localparam logic [2:0] ADDR_RESET  = 3'd1;
  localparam logic [2:0] ADDR_FREQLO = 3'd2;
  localparam logic [2:0] ADDR_FREQHI = 3'd3;
  localparam logic [2:0] ADDR_PRESC  = 3'd4;
  localparam logic [2:0] ADDR_CTRL   = 3'd5;
  localparam logic [2:0] ADDR_RSVD   = 3'd6;
  localparam logic [2:0] ADDR_COMMIT = 3'd7;

  // One full configuration set; used for both staging and active copies.
  typedef struct packed {
    logic [7:0]            set_val;
    logic [7:0]            reset_val;
    logic [7:0]            freq_hi;
    logic [7:0]            freq_lo;
    logic [PRESCALE_W-1:0] prescale;
    logic                  enable;
    logic                  value;
  } cfg_t;

  localparam cfg_t CFG_RST = '{
    set_val:   8'd0,
    reset_val: 8'd0,
    freq_hi:   8'd0,
    freq_lo:   8'd0,
    prescale:  PRESCALE_RST,
    enable:    1'b0,
    value:     1'b0
  };

  cfg_t                  stg_q,  stg_d;
  cfg_t                  act_q,  act_d;
  logic                  pend_q, pend_d;
  logic [CNT_W-1:0]      cnt_q,  cnt_d;
  logic [PRESCALE_W-1:0] lim_q,  lim_d;
  logic                  tick_q, tick_d;

  logic wr_fire;
  logic apply;
  logic wrap;

  // Write port, commit request and atomic commit apply.
  always_comb begin
    stg_d   = stg_q;
    act_d   = act_q;
    pend_d  = pend_q;
    wr_fire = wr_valid && !pend_q;
    // pend_q is still 0 in the request cycle, so the request cycle never applies.
    apply   = pend_q && (frame_sync || !act_q.enable);

    if (wr_fire) begin
      case (wr_addr)
        ADDR_SET:    stg_d.set_val   = wr_data;
        ADDR_RESET:  stg_d.reset_val = wr_data;
        ADDR_FREQLO: stg_d.freq_lo   = wr_data;
        ADDR_FREQHI: stg_d.freq_hi   = wr_data;
        ADDR_PRESC:  stg_d.prescale  = PRESCALE_W'(wr_data);
        ADDR_CTRL: begin
          stg_d.enable = wr_data[0];
          stg_d.value  = wr_data[1];
        end
        ADDR_RSVD:   ;
        ADDR_COMMIT: pend_d = 1'b1;
        default:     ;
      endcase
    end

    if (apply) begin
      act_d  = stg_q;
      pend_d = 1'b0;
    end
  end

  // Prescaler: counts 0..lim+1 while enabled; lim is only reloaded at a wrap
  // (or while idle) so a running period always completes with its old value.
  always_comb begin
    cnt_d  = '0;
    lim_d  = lim_q;
    tick_d = 1'b0;
    wrap   = (cnt_q == ({1'b0, lim_q} + CNT_W'(1)));

    if (!act_q.enable) begin
      lim_d = act_d.prescale;
    end else if (wrap) begin
      lim_d  = act_d.prescale;
      // Suppress the tick if the same edge commits a disable.
      tick_d = act_d.enable;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_q  <= CFG_RST;
      act_q  <= CFG_RST;
      pend_q <= 1'b0;
      cnt_q  <= '0;
      lim_q  <= PRESCALE_RST;
      tick_q <= 1'b0;
    end else begin
      stg_q  <= stg_d;
      act_q  <= act_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      lim_q  <= lim_d;
      tick_q <= tick_d;
    end
  end

`ifdef SERVO_CFG_READBACK_EN
  logic [7:0] rd_q, rd_d;

  // Staging readback; reserved address reads zero, commit address reads the pending flag.
  always_comb begin
    rd_d = 8'd0;
    case (rd_addr)
      ADDR_SET:    rd_d = stg_q.set_val;
      ADDR_RESET:  rd_d = stg_q.reset_val;
      ADDR_FREQLO: rd_d = stg_q.freq_lo;
      ADDR_FREQHI: rd_d = stg_q.freq_hi;
      ADDR_PRESC:  rd_d = 8'(stg_q.prescale);
      ADDR_CTRL:   rd_d = {6'd0, stg_q.value, stg_q.enable};
      ADDR_RSVD:   rd_d = 8'd0;
      ADDR_COMMIT: rd_d = {7'd0, pend_q};
      default:     rd_d = 8'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= 8'd0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign rd_data = rd_q;
`endif

  assign wr_ready        = !pend_q;
  assign commit_pending  = pend_q;
  assign servo_set_val   = act_q.set_val;
  assign servo_reset_val = act_q.reset_val;
  assign servo_freq_val  = {act_q.freq_hi, act_q.freq_lo};
  assign servo_enabled   = act_q.enable;
  assign servo_value     = act_q.value;
  assign servo_clk       = tick_q;

endmodule

// File: tb/tb_servo_cfg_tick.sv
// Directed bench for servo_cfg_tick: inputs driven and outputs sampled on the falling edge.
module tb_servo_cfg_tick;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [2:0]  wr_addr = 3'd0;
  logic [7:0]  wr_data = 8'd0;
  logic        frame_sync = 1'b0;
  logic        commit_pending;
  logic [7:0]  servo_set_val;
  logic [7:0]  servo_reset_val;
  logic [15:0] servo_freq_val;
  logic        servo_enabled;
  logic        servo_value;
  logic        servo_clk;
`ifdef SERVO_CFG_READBACK_EN
  logic [2:0]  rd_addr = 3'd0;
  logic [7:0]  rd_data;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  servo_cfg_tick dut (
    .clk             (clk),
    .rst             (rst),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .frame_sync      (frame_sync),
    .commit_pending  (commit_pending),
    .servo_set_val   (servo_set_val),
    .servo_reset_val (servo_reset_val),
    .servo_freq_val  (servo_freq_val),
    .servo_enabled   (servo_enabled),
    .servo_value     (servo_value),
    .servo_clk       (servo_clk)
`ifdef SERVO_CFG_READBACK_EN
    ,
    .rd_addr         (rd_addr),
    .rd_data         (rd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One accepted write; called just after a falling edge with wr_ready high.
  task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Falling edges until servo_clk is seen high; -1 if it never rises.
  task automatic measure_gap(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (servo_clk) begin
        n = i;
        break;
      end
    end
  endtask

  int gap;
  int highs;
  int bad;

  initial begin
    // Reset then idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_set",     32'(servo_set_val),   32'd0);
    check("rst_reset",   32'(servo_reset_val), 32'd0);
    check("rst_freq",    32'(servo_freq_val),  32'd0);
    check("rst_en",      32'(servo_enabled),   32'd0);
    check("rst_val",     32'(servo_value),     32'd0);
    check("rst_pending", 32'(commit_pending),  32'd0);
    check("rst_ready",   32'(wr_ready),        32'd1);
    check("rst_clk",     32'(servo_clk),       32'd0);
    highs = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (servo_clk !== 1'b0) highs++;
    end
    check("idle_clk_highs", 32'(highs), 32'd0);

    // Disabled commit: applies the cycle after the request
    write_reg(3'd0, 8'd10);
    write_reg(3'd1, 8'd20);
    write_reg(3'd2, 8'h00);
    write_reg(3'd3, 8'h01);
    write_reg(3'd4, 8'd3);
    write_reg(3'd5, 8'h03);
`ifdef SERVO_CFG_READBACK_EN
    rd_addr = 3'd0;
    @(negedge clk);
    check("rd_set", 32'(rd_data), 32'd10);
`endif
    check("stage_no_effect", 32'(servo_set_val), 32'd0);
    write_reg(3'd7, 8'hFF);
    check("dis_pending", 32'(commit_pending), 32'd1);
    check("dis_ready",   32'(wr_ready),       32'd0);
    check("dis_not_yet", 32'(servo_set_val),  32'd0);
    @(negedge clk);
    check("dis_pending_clr", 32'(commit_pending),  32'd0);
    check("dis_set",         32'(servo_set_val),   32'd10);
    check("dis_reset",       32'(servo_reset_val), 32'd20);
    check("dis_freq",        32'(servo_freq_val),  32'h0100);
    check("dis_en",          32'(servo_enabled),   32'd1);
    check("dis_val",         32'(servo_value),     32'd1);
    measure_gap(gap);
    check("first_tick", 32'(gap), 32'd5);
    @(negedge clk);
    check("tick_width", 32'(servo_clk), 32'd0);
    measure_gap(gap);
    check("tick_low_time", 32'(gap), 32'd4);
    measure_gap(gap);
    check("tick_period", 32'(gap), 32'd5);

    // Frame-aligned commit with a stalled write
    write_reg(3'd0, 8'd30);
    write_reg(3'd7, 8'd0);
    check("fa_pending", 32'(commit_pending), 32'd1);
    wr_valid = 1'b1;
    wr_addr  = 3'd0;
    wr_data  = 8'd55;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (servo_set_val !== 8'd10 || wr_ready !== 1'b0) bad++;
    end
    check("fa_hold", 32'(bad), 32'd0);
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
    wr_valid   = 1'b0;
    check("fa_set",     32'(servo_set_val),  32'd30);
    check("fa_ready",   32'(wr_ready),       32'd1);
    check("fa_pending_clr", 32'(commit_pending), 32'd0);

    // Commit request in the same cycle as frame_sync does not apply
    write_reg(3'd0, 8'd40);
    frame_sync = 1'b1;
    write_reg(3'd7, 8'd0);
    frame_sync = 1'b0;
    check("sc_pending", 32'(commit_pending), 32'd1);
    check("sc_not_applied", 32'(servo_set_val), 32'd30);
    repeat (3) @(negedge clk);
    check("sc_still_30", 32'(servo_set_val), 32'd30);
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
    check("sc_set", 32'(servo_set_val), 32'd40);

    // Prescale change mid-period: old period finishes, then period 2
    measure_gap(gap);
    write_reg(3'd4, 8'd0);
    write_reg(3'd7, 8'd0);
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
    check("pc_applied", 32'(commit_pending), 32'd0);
    measure_gap(gap);
    check("pc_old_period_tail", 32'(gap), 32'd2);
    measure_gap(gap);
    check("pc_new_period", 32'(gap), 32'd2);
    @(negedge clk);
    check("pc_width", 32'(servo_clk), 32'd0);

    // Reset while a commit is pending discards it
    write_reg(3'd0, 8'd77);
    write_reg(3'd7, 8'd0);
    check("rp_pending", 32'(commit_pending), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rp_pending_clr", 32'(commit_pending), 32'd0);
    check("rp_set",   32'(servo_set_val),  32'd0);
    check("rp_en",    32'(servo_enabled),  32'd0);
    check("rp_freq",  32'(servo_freq_val), 32'd0);
    check("rp_clk",   32'(servo_clk),      32'd0);
    check("rp_ready", 32'(wr_ready),       32'd1);
    write_reg(3'd7, 8'd0);
    @(negedge clk);
    check("rp_staged_lost_set", 32'(servo_set_val), 32'd0);
    check("rp_staged_lost_en",  32'(servo_enabled), 32'd0);
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (servo_clk !== 1'b0) highs++;
    end
    check("rp_clk_idle", 32'(highs), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
